// File: rtl/capture_analyzer.sv
// capture_analyzer: on-chip logic-analyzer capture core.
// Records data_i into a circular buffer and stops DEPTH samples after the
// window start. The window is placed around a masked-compare trigger on
// trig_i. After the capture completes, samples are read back in
// chronological order. Index 0 is the oldest sample in the window.
//
// Handshake (read port): rd_en_i is a one-cycle request and has no ready
// signal. A request accepted in DONE produces rd_valid_o=1 with rd_data_o
// exactly one cycle later. One request per cycle is accepted. A request
// made outside DONE yields rd_valid_o=0 and leaves rd_data_o untouched.
module capture_analyzer #(
  parameter int DATA_W = 47,
  parameter int TRIG_W = 10,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [ADDR_W-1:0] pre_trig_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_index_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [TRIG_W-1:0]   value_q, value_d;
  logic [TRIG_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   pre_trig_q, pre_trig_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                triggered_q, triggered_d;
  logic                hit_prev_q, hit_prev_d;
  logic                first_q, first_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                hit_eq;
  logic                fire;
  logic                capturing;
  logic                wr_en;
  logic                rd_fire;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W-1:0]   rd_phys;

  assign capturing  = (state_q == ST_PRE) || (state_q == ST_ARMED) ||
                      (state_q == ST_POST);
  // The arm/abort cycle itself writes nothing; the first sample lands the cycle after arm.
  assign wr_en      = capturing && !arm_i && !abort_i;
  assign rd_fire    = rd_en_i && (state_q == ST_DONE);
  assign start_addr = trig_addr_q - pre_trig_q;
  assign rd_phys    = start_addr + rd_addr_i;
  assign hit_eq     = ((trig_i ^ value_q) & mask_q) == '0;

  // Trigger condition for the latched mode; only consulted while ARMED.
  always_comb begin
    fire = 1'b0;
    case (mode_q)
      2'b00:   fire = hit_eq;
      2'b01:   fire = !hit_eq;
      2'b10:   fire = hit_eq && !hit_prev_q;
      default: fire = first_q;
    endcase
  end

  // Next-state, configuration latch, pointer and counter updates.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    value_d     = value_q;
    mask_d      = mask_q;
    pre_trig_d  = pre_trig_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    first_d     = 1'b0;
    hit_prev_d  = capturing ? hit_eq : 1'b0;
    rd_valid_d  = rd_fire;

    if (abort_i) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
    end else if (arm_i) begin
      mode_d      = trig_mode_i;
      value_d     = trig_value_i;
      mask_d      = trig_mask_i;
      pre_trig_d  = pre_trig_i;
      wr_ptr_d    = '0;
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      hit_prev_d  = 1'b0;
      if (pre_trig_i == '0) begin
        state_d = ST_ARMED;
        first_d = 1'b1;
      end else begin
        state_d = ST_PRE;
      end
    end else begin
      case (state_q)
        ST_PRE: begin
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          pre_cnt_d = pre_cnt_q + ADDR_W'(1);
          if (pre_cnt_q == pre_trig_q - ADDR_W'(1)) begin
            state_d = ST_ARMED;
            first_d = 1'b1;
          end
        end
        ST_ARMED: begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (fire) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            post_cnt_d  = ADDR_W'(DEPTH - 1) - pre_trig_q;
            if (pre_trig_q == ADDR_W'(DEPTH - 1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
          post_cnt_d = post_cnt_q - ADDR_W'(1);
          if (post_cnt_q == ADDR_W'(1)) begin
            state_d = ST_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      pre_trig_q  <= '0;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      hit_prev_q  <= 1'b0;
      first_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      mask_q      <= mask_d;
      pre_trig_q  <= pre_trig_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      hit_prev_q  <= hit_prev_d;
      first_q     <= first_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Capture buffer write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // Registered RAM read; holds its value when no read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign state_o      = state_q;
  assign triggered_o  = triggered_q;
  assign done_o       = (state_q == ST_DONE);
  assign trig_index_o = pre_trig_q;

endmodule

// File: tb/tb_capture_analyzer.sv
// tb_capture_analyzer: directed bench for capture_analyzer at DEPTH=16.
// Probe data is a counter that starts at 0 on the first write cycle after arm.
// Read results are checked against a queue of expected samples.
module tb_capture_analyzer;

  localparam int DATA_W = 47;
  localparam int TRIG_W = 10;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_i;
  logic              arm_i;
  logic              abort_i;
  logic [1:0]        trig_mode_i;
  logic [TRIG_W-1:0] trig_value_i;
  logic [TRIG_W-1:0] trig_mask_i;
  logic [ADDR_W-1:0] pre_trig_i;
  logic [TRIG_W-1:0] trig_i;
  logic [DATA_W-1:0] data_i;
  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic [2:0]        state_o;
  logic              triggered_o;
  logic              done_o;
  logic [ADDR_W-1:0] trig_index_o;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd = '0;
  logic [DATA_W-1:0] ctr = '0;
  logic              ctr_run = 1'b0;
  logic              trig_follow = 1'b1;
  int                n;

  capture_analyzer #(
    .DATA_W(DATA_W),
    .TRIG_W(TRIG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .trig_mode_i (trig_mode_i),
    .trig_value_i(trig_value_i),
    .trig_mask_i (trig_mask_i),
    .pre_trig_i  (pre_trig_i),
    .trig_i      (trig_i),
    .data_i      (data_i),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .state_o     (state_o),
    .triggered_o (triggered_o),
    .done_o      (done_o),
    .trig_index_o(trig_index_o)
  );

  // Clock and global time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (ctr_run) begin
      data_i = ctr;
      if (trig_follow) trig_i = ctr[TRIG_W-1:0];
      ctr = ctr + 1'b1;
    end
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [TRIG_W-1:0] v,
                        input logic [TRIG_W-1:0] mk, input logic [ADDR_W-1:0] p);
    trig_mode_i  = m;
    trig_value_i = v;
    trig_mask_i  = mk;
    pre_trig_i   = p;
    arm_i        = 1'b1;
    ctr          = '0;
    ctr_run      = 1'b1;
    cycle();
    arm_i        = 1'b0;
  endtask

  task automatic wait_trig(input int budget, output int cnt);
    cnt = 0;
    while (!triggered_o && cnt < budget) begin
      cycle();
      cnt++;
    end
    if (!triggered_o) cnt = -1;
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    while (!done_o && cnt < budget) begin
      cycle();
      cnt++;
    end
    if (!done_o) cnt = -1;
  endtask

  task automatic push_ramp(input int base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(DATA_W'(base + i));
  endtask

  // Issue back-to-back reads; each response is popped against the scoreboard.
  task automatic read_burst(input int first, input int len);
    logic [DATA_W-1:0] e;
    for (int i = 0; i < len; i++) begin
      rd_en_i   = 1'b1;
      rd_addr_i = ADDR_W'(first + i);
      cycle();
      chk("rd_valid", 64'(rd_valid_o), 64'(1));
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 64'(rd_data_o), 64'(e));
        last_rd = e;
      end
    end
    rd_en_i = 1'b0;
    cycle();
    chk("rd_valid_idle", 64'(rd_valid_o), 64'(0));
    chk("rd_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0; trig_mode_i = '0;
    trig_value_i = '0; trig_mask_i = '0; pre_trig_i = '0; trig_i = '0;
    data_i = '0; rd_en_i = 1'b0; rd_addr_i = '0;
    repeat (3) cycle();
    rst_i = 1'b0;
    cycle();
    chk("rst_state", 64'(state_o), 64'(0));
    chk("rst_trig", 64'(triggered_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid_o), 64'(0));
    chk("rst_rd_data", 64'(rd_data_o), 64'(0));
    chk("rst_trig_index", 64'(trig_index_o), 64'(0));

    // Mode 00, pre 4, trigger on counter value 10.
    do_arm(2'b00, 10'h00A, 10'h3FF, 4'd4);
    chk("t1_state_pre", 64'(state_o), 64'(1));
    wait_trig(40, n);
    chk("t1_trig_lat", 64'(n), 64'(11));
    wait_done(40, n);
    chk("t1_done_lat", 64'(n), 64'(11));
    chk("t1_state_done", 64'(state_o), 64'(4));
    chk("t1_trig_index", 64'(trig_index_o), 64'(4));
    push_ramp(6, 16);
    read_burst(0, 16);
    exp_q.push_back(DATA_W'(10));
    read_burst(4, 1);

    // Mode 10, trigger bus held at match from arm, then dropped and restored.
    trig_follow = 1'b0;
    trig_i = 10'h155;
    do_arm(2'b10, 10'h155, 10'h3FF, 4'd2);
    repeat (8) cycle();
    chk("t2_state_armed", 64'(state_o), 64'(2));
    chk("t2_no_trig_held", 64'(triggered_o), 64'(0));
    trig_i = 10'h000;
    repeat (2) cycle();
    chk("t2_no_trig_low", 64'(triggered_o), 64'(0));
    trig_i = 10'h155;
    wait_trig(40, n);
    chk("t2_trig_lat", 64'(n), 64'(1));
    wait_done(40, n);
    chk("t2_done_lat", 64'(n), 64'(13));
    trig_follow = 1'b1;
    push_ramp(8, 16);
    read_burst(0, 16);

    // Mode 11 with pre 0: first sample after arm is the trigger sample.
    do_arm(2'b11, 10'h000, 10'h3FF, 4'd0);
    chk("t3_state_armed", 64'(state_o), 64'(2));
    wait_trig(40, n);
    chk("t3_trig_lat", 64'(n), 64'(1));
    wait_done(40, n);
    chk("t3_done_lat", 64'(n), 64'(15));
    chk("t3_trig_index", 64'(trig_index_o), 64'(0));
    push_ramp(0, 16);
    read_burst(0, 16);

    // Pre 15: trigger is the last sample of the window.
    do_arm(2'b00, 10'h014, 10'h3FF, 4'd15);
    wait_trig(60, n);
    chk("t4_trig_lat", 64'(n), 64'(21));
    chk("t4_done_with_trig", 64'(done_o), 64'(1));
    chk("t4_trig_index", 64'(trig_index_o), 64'(15));
    push_ramp(5, 16);
    read_burst(0, 16);

    // Abort during POST, then a fresh capture with different configuration.
    do_arm(2'b00, 10'h00A, 10'h3FF, 4'd4);
    wait_trig(40, n);
    chk("t5_trig_lat", 64'(n), 64'(11));
    repeat (3) cycle();
    chk("t5_state_post", 64'(state_o), 64'(3));
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    chk("t5_abort_state", 64'(state_o), 64'(0));
    chk("t5_abort_done", 64'(done_o), 64'(0));
    chk("t5_abort_trig", 64'(triggered_o), 64'(0));
    rd_en_i = 1'b1;
    rd_addr_i = '0;
    cycle();
    rd_en_i = 1'b0;
    chk("t5_idle_rd_valid", 64'(rd_valid_o), 64'(0));
    chk("t5_idle_rd_hold", 64'(rd_data_o), 64'(last_rd));
    arm_i = 1'b1;
    abort_i = 1'b1;
    cycle();
    arm_i = 1'b0;
    abort_i = 1'b0;
    chk("t5_abort_wins", 64'(state_o), 64'(0));
    do_arm(2'b01, 10'h003, 10'h00F, 4'd3);
    wait_trig(40, n);
    chk("t5b_trig_lat", 64'(n), 64'(5));
    wait_done(40, n);
    chk("t5b_done_lat", 64'(n), 64'(12));
    chk("t5b_trig_index", 64'(trig_index_o), 64'(3));
    push_ramp(1, 16);
    read_burst(0, 16);

    // Reset while ARMED; reads outside DONE.
    do_arm(2'b00, 10'h3FF, 10'h3FF, 4'd2);
    repeat (4) cycle();
    chk("t6_state_armed", 64'(state_o), 64'(2));
    rd_en_i = 1'b1;
    cycle();
    rd_en_i = 1'b0;
    chk("t6_armed_rd_valid", 64'(rd_valid_o), 64'(0));
    chk("t6_armed_rd_hold", 64'(rd_data_o), 64'(last_rd));
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("t6_rst_state", 64'(state_o), 64'(0));
    chk("t6_rst_trig", 64'(triggered_o), 64'(0));
    chk("t6_rst_done", 64'(done_o), 64'(0));
    chk("t6_rst_rd_valid", 64'(rd_valid_o), 64'(0));
    chk("t6_rst_rd_data", 64'(rd_data_o), 64'(0));
    chk("t6_rst_trig_index", 64'(trig_index_o), 64'(0));
    rd_en_i = 1'b1;
    cycle();
    rd_en_i = 1'b0;
    chk("t6_idle_rd_valid", 64'(rd_valid_o), 64'(0));
    chk("t6_idle_rd_data", 64'(rd_data_o), 64'(0));
    ctr_run = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_analyzer.md
Name: capture_analyzer

Overview:
- Parametrised on-chip logic-analyzer capture core for debugging the video transmitter. Examples: TMDS encoder stages, pixel counters.
- Records a DATA_W-bit probe bus into a circular buffer and triggers on a masked compare of a TRIG_W-bit trigger bus.
- Supports a programmable pre-trigger depth and four trigger modes.
- Captured samples are read back over a simple synchronous read port, in chronological order relative to the start of the capture window.

Parameters:
- DATA_W, 47, width of captured probe bus
- TRIG_W, 10, width of trigger bus
- DEPTH, 1024, capture buffer depth in samples; must be a power of two, >= 4
- ADDR_W, $clog2(DEPTH), buffer address width; derived from DEPTH, not overridden

Ports:
- clk_i  in  1  capture clock; all logic in this single domain
- rst_i  in  1  synchronous, active-high reset
- arm_i  in  1  single-cycle pulse; starts a new capture and latches configuration
- abort_i  in  1  single-cycle pulse; returns the core to IDLE
- trig_mode_i  in  2  trigger mode: 00 = masked equal, 01 = masked not-equal, 10 = rising match, 11 = immediate
- trig_value_i  in  TRIG_W  trigger compare value
- trig_mask_i  in  TRIG_W  compare mask; 1 = bit participates
- pre_trig_i  in  ADDR_W  number of samples kept before the trigger sample
- trig_i  in  TRIG_W  live trigger bus
- data_i  in  DATA_W  live probe bus
- rd_en_i  in  1  read request
- rd_addr_i  in  ADDR_W  logical sample index; 0 = oldest sample in the window
- rd_data_o  out  DATA_W  read data
- rd_valid_o  out  1  rd_data_o valid
- state_o  out  3  current state: 0 IDLE, 1 PRE, 2 ARMED, 3 POST, 4 DONE
- triggered_o  out  1  trigger has occurred in the current capture
- done_o  out  1  capture complete; buffer readable
- trig_index_o  out  ADDR_W  logical index of the trigger sample; equals the latched pre-trigger count

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state goes to IDLE; write pointer and counters clear.
  - rd_valid_o=0, triggered_o=0, done_o=0, trig_index_o=0; rd_data_o holds 0 until the first valid read.
  - Buffer RAM contents are not cleared.
  - Reset mid-capture behaves identically.
- Arming:
  - arm_i accepted in any state. It latches trig_mode, trig_value, trig_mask and pre_trig, clears wr_ptr, sample count, triggered_o and done_o, and enters PRE.
  - If pre_trig=0, it enters ARMED directly.
  - If arm_i and abort_i are asserted in the same cycle, abort_i wins.
- Writing:
  - In PRE, ARMED and POST, data_i is written to mem[wr_ptr] every cycle, starting in the first cycle after arm_i.
  - wr_ptr increments modulo DEPTH and wraps freely in ARMED.
- PRE:
  - Counts written samples. After pre_trig samples, moves to ARMED.
  - Triggers are ignored while in PRE.
- Trigger compare:
  - hit_eq = ((trig_i ^ trig_value) & trig_mask) == 0.
  - Mode 00 fires on hit_eq; mode 01 fires on !hit_eq.
  - Mode 10 fires on hit_eq && !hit_eq_prev. hit_eq_prev is registered every cycle from arm onward and is cleared on arm.
  - Mode 11 fires in the first ARMED cycle.
  - An all-zero mask makes mode 00 fire immediately.
- ARMED, on a hit:
  - The sample written in that same cycle is the trigger sample.
  - Record trig_addr = wr_ptr, set triggered_o=1, load post_cnt = DEPTH-1-pre_trig.
  - If post_cnt=0, go to DONE after this write; otherwise go to POST.
- POST:
  - Writes and decrements post_cnt. On the cycle that writes the last sample, moves to DONE.
  - Total samples per window = DEPTH.
- DONE:
  - Writes stop; done_o=1.
  - start_addr = (trig_addr - pre_trig) mod DEPTH.
  - trig_index_o = pre_trig.
- Abort: abort_i returns to IDLE. triggered_o and done_o clear; buffer contents are retained but not readable.
- Read port:
  - In DONE, rd_en_i issues a read of mem[(start_addr + rd_addr_i) mod DEPTH].
  - rd_data_o and rd_valid_o appear exactly one cycle later; back-to-back reads are supported, one per cycle.
  - rd_en_i outside DONE produces rd_valid_o=0 the next cycle and leaves rd_data_o unchanged.
- Widths and mapping:
  - pre_trig_i values above DEPTH-1 cannot occur, since it is ADDR_W wide.
  - pre_trig = DEPTH-1 is legal; the trigger sample is then the last sample in the window.
- The buffer maps to inferred block RAM: registered read, single write port.

Test Plan:
- DEPTH=16, pre_trig=4, mode 00, mask=0x3FF, value=0x00A; data_i = trig_i = free-running counter from 0 at arm:
  - Expect triggered_o when trig_i=0x00A and done_o 11 cycles later.
  - Reading indices 0..15 returns 6..21; trig_index_o=4 and index 4 reads 0x00A.
- Mode 10 with the trigger bus held at the match value from arm:
  - Expect no trigger until the bus deasserts and re-asserts.
  - The trigger sample is at the re-assert cycle.
- pre_trig=0 with mode 11: trigger fires on the first cycle; index 0 equals the first sample after arm; done_o after 16 writes.
- pre_trig=15: trigger at counter value 20 with counter data; done_o the cycle after the trigger write; index 15 reads 20.
- abort_i during POST, then a new arm:
  - Expect state_o=0 and done_o=0 after the abort.
  - The second capture completes correctly with fresh configuration.
- rst_i asserted in ARMED, and rd_en_i while not in DONE: expect all outputs at reset values and rd_valid_o=0.
